// File: rtl/coherent_bus_ctrl.sv
// coherent_bus_ctrl: round-robin I/D arbiter with snoop broadcast, cache-to-cache transfer and snoop timeout
module coherent_bus_ctrl #(
  parameter int NCPU      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SNOOP_TMO = 15
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCPU-1:0]          iREN,
  input  logic [NCPU-1:0][AW-1:0]  iaddr,
  output logic [NCPU-1:0]          iwait,
  output logic [NCPU-1:0][DW-1:0]  iload,
  input  logic [NCPU-1:0]          dREN,
  input  logic [NCPU-1:0]          dWEN,
  input  logic [NCPU-1:0][AW-1:0]  daddr,
  input  logic [NCPU-1:0][DW-1:0]  dstore,
  output logic [NCPU-1:0]          dwait,
  output logic [NCPU-1:0][DW-1:0]  dload,
  input  logic [NCPU-1:0]          cctrans,
  input  logic [NCPU-1:0]          ccwrite,
  input  logic [NCPU-1:0]          ccack,
  input  logic [NCPU-1:0]          cchit,
  output logic [NCPU-1:0]          ccwait,
  output logic [NCPU-1:0]          ccinv,
  output logic [NCPU-1:0][AW-1:0]  ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore,
  input  logic [DW-1:0]            ramload,
  input  logic [1:0]               ramstate,
  output logic                     snoop_err
);
  localparam int IW = $clog2(NCPU);
  localparam logic [1:0] RAM_BUSY = 2'd1, RAM_ACCESS = 2'd2, RAM_ERROR = 2'd3;
  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, FETCH} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, src_q, src_d, dptr_q, dptr_d, iptr_q, iptr_d;
  logic [7:0] tmo_q, tmo_d;
  logic snoop_err_q, snoop_err_d;
  logic [IW-1:0] g, k, lowhit;
  logic [NCPU-1:0] others, hits;
  logic all_ack, hold, acc;

  function automatic logic [IW-1:0] rr_pick(input logic [NCPU-1:0] req, input logic [IW-1:0] ptr);
    rr_pick = '0;
    for (int i = NCPU-1; i >= 0; i--) begin
      logic [IW:0] s;
      logic [IW-1:0] idx;
      s = {1'b0, ptr} + (IW+1)'(i);
      idx = (s >= (IW+1)'(NCPU)) ? IW'(s - (IW+1)'(NCPU)) : IW'(s);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    inc = (p == IW'(NCPU-1)) ? '0 : p + IW'(1);
  endfunction

  assign g         = rr_pick(dREN | dWEN, dptr_q);
  assign k         = rr_pick(iREN, iptr_q);
  assign others    = ~(NCPU'(1) << gnt_q);
  assign hits      = cchit & ccack & others;
  assign lowhit    = rr_pick(hits, '0);
  assign all_ack   = &(ccack | ~others);
  assign acc       = ramstate == RAM_ACCESS;
  assign hold      = ramstate == RAM_BUSY || ramstate == RAM_ERROR;
  assign snoop_err = snoop_err_q;

  // next-state: grants, snoop resolution and pointer/timeout bookkeeping; frozen while RAM is busy or faulted
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    src_d       = src_q;
    dptr_d      = dptr_q;
    iptr_d      = iptr_q;
    tmo_d       = tmo_q;
    snoop_err_d = snoop_err_q;
    if (!hold) begin
      case (state_q)
        IDLE: begin
          if (|(dREN | dWEN)) begin
            gnt_d   = g;
            dptr_d  = inc(g);
            tmo_d   = '0;
            state_d = (dWEN[g] && !cctrans[g]) ? WB : cctrans[g] ? SNOOP : FETCH;
          end else if (|iREN && acc) iptr_d = inc(k);
        end
        WB:    if (!dWEN[gnt_q]) state_d = IDLE;
        SNOOP: begin
          tmo_d = tmo_q + 8'd1;
          if (all_ack) begin
            src_d   = lowhit;
            state_d = |hits ? C2C : FETCH;
          end else if (tmo_q == 8'(SNOOP_TMO)) begin
            snoop_err_d = 1'b1;
            state_d     = FETCH;
          end
        end
        C2C:     if (!(dREN[gnt_q] && dWEN[src_q])) state_d = IDLE;
        FETCH:   if (!dREN[gnt_q]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // outputs: combinational from state and inputs; everything at defaults while reset is asserted
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (nRST) begin
      case (state_q)
        IDLE: begin
          if (!(|(dREN | dWEN)) && |iREN) begin
            ramREN   = 1'b1;
            ramaddr  = iaddr[k];
            iload[k] = ramload;
            iwait[k] = !acc;
          end
        end
        WB: begin
          ramWEN       = 1'b1;
          ramaddr      = daddr[gnt_q];
          ramstore     = dstore[gnt_q];
          dwait[gnt_q] = !acc;
        end
        SNOOP: begin
          ccwait             = others;
          ccinv              = others & {NCPU{ccwrite[gnt_q]}};
          ccsnoopaddr        = {NCPU{daddr[gnt_q]}};
          ccsnoopaddr[gnt_q] = '0;
        end
        C2C: begin
          ccwait[src_q] = 1'b1;
          dload[gnt_q]  = dstore[src_q];
          ramWEN        = 1'b1;
          ramaddr       = daddr[src_q];
          ramstore      = dstore[src_q];
          dwait[gnt_q]  = !acc;
          dwait[src_q]  = !acc;
        end
        FETCH: begin
          ramREN       = 1'b1;
          ramaddr      = daddr[gnt_q];
          dload[gnt_q] = ramload;
          dwait[gnt_q] = !acc;
        end
        default: ;
      endcase
    end
  end

  // state register with asynchronous active-low reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      src_q       <= '0;
      dptr_q      <= '0;
      iptr_q      <= '0;
      tmo_q       <= '0;
      snoop_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      src_q       <= src_d;
      dptr_q      <= dptr_d;
      iptr_q      <= iptr_d;
      tmo_q       <= tmo_d;
      snoop_err_q <= snoop_err_d;
    end
  end
endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// tb_coherent_bus_ctrl: scenario tasks with a completion scoreboard for the 4-core controller
module tb_coherent_bus_ctrl;
  localparam int N = 4;
  localparam logic [31:0] K = 32'hC0DE_0000;
  localparam logic [1:0] FREE = 2'd0, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK, nRST;
  logic [N-1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccack, cchit, ccwait, ccinv;
  logic [N-1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic ramREN, ramWEN, snoop_err;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;

  typedef struct { int c; logic [31:0] v; } exp_t;
  exp_t dq[$], iq[$];
  int errors = 0, checks = 0;

  coherent_bus_ctrl #(.NCPU(N), .AW(32), .DW(32), .SNOOP_TMO(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccack(ccack), .cchit(cchit), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .snoop_err(snoop_err));

  assign ramload = ramaddr ^ K;

  initial CLK = 0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard: every completed read word is matched against the oldest expectation
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      for (int c = 0; c < N; c++) begin
        if (!dwait[c] && dREN[c]) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL dload_unexpected: core %0d completed with %h, none expected", c, dload[c]);
          end else begin
            e = dq.pop_front();
            if (e.c != c || dload[c] !== e.v) begin
              errors++;
              $display("FAIL dload: got core %0d data %h, want core %0d data %h", c, dload[c], e.c, e.v);
            end
          end
        end
        if (!iwait[c] && iREN[c]) begin
          checks++;
          if (iq.size() == 0) begin
            errors++;
            $display("FAIL iload_unexpected: core %0d completed with %h, none expected", c, iload[c]);
          end else begin
            e = iq.pop_front();
            if (e.c != c || iload[c] !== e.v) begin
              errors++;
              $display("FAIL iload: got core %0d data %h, want core %0d data %h", c, iload[c], e.c, e.v);
            end
          end
        end
      end
    end
  end

  task automatic drv_read(input int c, input logic [31:0] a, input logic tr);
    int n;
    dREN[c] = 1'b1;
    daddr[c] = a;
    cctrans[c] = tr;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (dwait[c] && n < 100);
    if (dwait[c]) begin
      errors++;
      checks++;
      $display("FAIL read_timeout core %0d: dwait=%b, want 0", c, dwait[c]);
    end
    @(posedge CLK);
    #1;
    dREN[c] = 1'b0;
    cctrans[c] = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 0;
    dREN = '1;
    iREN = '1;
    daddr[0] = 32'h10;
    repeat (2) @(negedge CLK);
    checks += 5;
    if (iwait !== 4'hF) begin errors++; $display("FAIL reset_iwait: got %b want 1111", iwait); end
    if (dwait !== 4'hF) begin errors++; $display("FAIL reset_dwait: got %b want 1111", dwait); end
    if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN: got %b want 0", ramREN); end
    if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN: got %b want 0", ramWEN); end
    if (snoop_err !== 1'b0) begin errors++; $display("FAIL reset_snoop_err: got %b want 0", snoop_err); end
    dq.push_back('{0, 32'h10 ^ K});
    nRST = 1;
    @(negedge CLK);
    checks += 2;
    if (dwait !== 4'b1110) begin errors++; $display("FAIL first_grant_dwait: got %b want 1110", dwait); end
    if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin errors++; $display("FAIL first_grant_ram: got ren=%b addr=%h want ren=1 addr=00000010", ramREN, ramaddr); end
    @(posedge CLK);
    #1 nRST = 0;
    #1;
    checks += 2;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL abort_ram: got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
    if (dwait !== 4'hF) begin errors++; $display("FAIL abort_dwait: got %b want 1111", dwait); end
    dREN = '0;
    iREN = '0;
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_round_robin;
    @(posedge CLK);
    #1;
    dq.push_back('{1, 32'h1000 ^ K});
    dq.push_back('{3, 32'h3000 ^ K});
    dq.push_back('{1, 32'h1100 ^ K});
    fork
      begin
        drv_read(1, 32'h1000, 1'b1);
        @(posedge CLK);
        #1;
        drv_read(1, 32'h1100, 1'b1);
      end
      drv_read(3, 32'h3000, 1'b1);
    join
  endtask

  task automatic test_c2c;
    int n;
    @(posedge CLK);
    #1;
    ccack = '0;
    dq.push_back('{0, 32'hDEADBEEF});
    dREN[0] = 1;
    cctrans[0] = 1;
    ccwrite[0] = 1;
    daddr[0] = 32'h100;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ccwait == 4'b0 && n < 20);
    checks += 3;
    if (ccwait !== 4'b1110) begin errors++; $display("FAIL snoop_ccwait: got %b want 1110", ccwait); end
    if (ccinv !== 4'b1110) begin errors++; $display("FAIL snoop_ccinv: got %b want 1110", ccinv); end
    if (ccsnoopaddr[0] !== 32'h0) begin errors++; $display("FAIL snoop_addr0: got %h want 00000000", ccsnoopaddr[0]); end
    for (int j = 1; j < N; j++) begin
      checks++;
      if (ccsnoopaddr[j] !== 32'h100) begin errors++; $display("FAIL snoop_addr%0d: got %h want 00000100", j, ccsnoopaddr[j]); end
    end
    dstore[2] = 32'hDEADBEEF;
    daddr[2] = 32'h2000;
    dWEN[2] = 1;
    cchit = 4'b0100;
    ccack = 4'b1110;
    @(negedge CLK);
    checks += 4;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL c2c_ram_en: got ren=%b wen=%b want 0 1", ramREN, ramWEN); end
    if (ramaddr !== 32'h2000 || ramstore !== 32'hDEADBEEF) begin errors++; $display("FAIL c2c_ram: got addr=%h data=%h want 00002000 deadbeef", ramaddr, ramstore); end
    if (dwait !== 4'b1010) begin errors++; $display("FAIL c2c_dwait: got %b want 1010", dwait); end
    if (ccwait !== 4'b0100) begin errors++; $display("FAIL c2c_ccwait: got %b want 0100", ccwait); end
    @(posedge CLK);
    #1;
    dREN[0] = 0;
    dWEN[2] = 0;
    cctrans = '0;
    ccwrite = '0;
    cchit = '0;
    ccack = '1;
    @(posedge CLK);
  endtask

  task automatic test_timeout;
    int n;
    @(posedge CLK);
    #1;
    ccack = 4'b1101;
    dq.push_back('{0, 32'h500 ^ K});
    fork
      drv_read(0, 32'h500, 1'b1);
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (!ccwait[1] && n < 20);
        checks++;
        if (snoop_err !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b want 0", snoop_err); end
        n = 0;
        while (ccwait[1] && n < 20) begin
          n++;
          @(negedge CLK);
        end
        checks += 3;
        if (n != 5) begin errors++; $display("FAIL tmo_cycles: got %0d snoop cycles want 5", n); end
        if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin errors++; $display("FAIL tmo_fetch: got ren=%b addr=%h want 1 00000500", ramREN, ramaddr); end
        if (snoop_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", snoop_err); end
      end
    join
    ccack = '1;
  endtask

  task automatic test_wb_priority;
    @(posedge CLK);
    #1;
    iq.push_back('{0, 32'h40 ^ K});
    dWEN[1] = 1;
    cctrans[1] = 0;
    daddr[1] = 32'h300;
    dstore[1] = 32'h1234;
    iREN[0] = 1;
    iaddr[0] = 32'h40;
    @(negedge CLK);
    checks++;
    if (iwait[0] !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL wb_idle: got iwait0=%b ren=%b want 1 0", iwait[0], ramREN); end
    @(negedge CLK);
    checks += 3;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h300 || ramstore !== 32'h1234) begin errors++; $display("FAIL wb_ram: got wen=%b addr=%h data=%h want 1 00000300 00001234", ramWEN, ramaddr, ramstore); end
    if (dwait !== 4'b1101) begin errors++; $display("FAIL wb_dwait: got %b want 1101", dwait); end
    if (iwait !== 4'hF) begin errors++; $display("FAIL wb_iwait: got %b want 1111", iwait); end
    @(posedge CLK);
    #1 dWEN[1] = 0;
    @(negedge CLK);
    checks++;
    if (iwait[0] !== 1'b1) begin errors++; $display("FAIL wb_tail_iwait: got %b want 1", iwait[0]); end
    @(negedge CLK);
    checks += 2;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_ram: got ren=%b addr=%h want 1 00000040", ramREN, ramaddr); end
    if (iwait !== 4'b1110) begin errors++; $display("FAIL ifetch_iwait: got %b want 1110", iwait); end
    @(posedge CLK);
    #1 iREN[0] = 0;
  endtask

  task automatic test_ram_error;
    @(posedge CLK);
    #1;
    ramstate = FREE;
    dq.push_back('{2, 32'h700 ^ K});
    dREN[2] = 1;
    cctrans[2] = 0;
    daddr[2] = 32'h700;
    @(posedge CLK);
    #1 ramstate = ERROR;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (dwait[2] !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h700) begin errors++; $display("FAIL err_hold: got dwait2=%b ren=%b addr=%h want 1 1 00000700", dwait[2], ramREN, ramaddr); end
    end
    @(posedge CLK);
    #1 ramstate = ACCESS;
    @(negedge CLK);
    checks++;
    if (dwait !== 4'b1011) begin errors++; $display("FAIL err_release_dwait: got %b want 1011", dwait); end
    @(posedge CLK);
    #1 dREN[2] = 0;
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    nRST = 0;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0; ccack = '1; cchit = '0; ramstate = ACCESS;
    test_reset();
    test_round_robin();
    test_c2c();
    test_timeout();
    test_wb_priority();
    test_ram_error();
    repeat (3) @(posedge CLK);
    checks += 2;
    if (dq.size() != 0) begin errors++; $display("FAIL dq_leftover: got %0d pending want 0", dq.size()); end
    if (iq.size() != 0) begin errors++; $display("FAIL iq_leftover: got %0d pending want 0", iq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
